sram_ring_logger: RTL and testbench

Avalon-MM master that drives the single-port on-chip SRAM slave and runs it as a circular sample log. It accepts 32-bit temperature samples on a valid/ready sink and writes each one to the next SRAM word, overwriting the oldest entry when the log is full. On request it dumps the log oldest-first through a valid/ready source. It sits between the sensor sampling path and the SRAM, in place of the processor's data master.

---
 rtl/sram_ring_logger.sv | 165 ++++++++++++++++
 tb/tb_sram_ring_logger.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ring_logger.sv
// sram_ring_logger: Avalon-MM master that runs a single-port SRAM as a circular
// log of 32-bit samples. New samples overwrite the oldest entry once the log is full.
// A dump request streams the log out oldest-first. Each entry is removed from the
// log once the consumer has taken it.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   snk_valid/data/ready sample sink (valid/ready)
//   dump_start, clear    one-cycle requests: start a dump / empty the log
//   dump_busy            high while a dump is in progress
//   src_valid/data/ready dump word source (valid/ready)
//   count, overflow      stored entries (0..DEPTH), sticky overwrite flag
//   avm_*                registered Avalon-MM master to the SRAM (no waitrequest)
module sram_ring_logger #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1   // 1 or 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snk_valid,
  input  logic [31:0]       snk_data,
  output logic              snk_ready,
  input  logic              dump_start,
  input  logic              clear,
  output logic              dump_busy,
  output logic              src_valid,
  output logic [31:0]       src_data,
  input  logic              src_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StHold} state_e;

  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        wait_q, wait_d;
  logic [31:0]       src_data_q, src_data_d;
  logic              avm_chipselect_q, avm_chipselect_d;
  logic              avm_write_q, avm_write_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [31:0]       avm_writedata_q, avm_writedata_d;
  logic              accept;

  // Samples are only taken in idle; clear and reset block acceptance in their cycle.
  assign snk_ready      = (state_q == StIdle) & ~clear & ~reset;
  assign accept         = snk_valid & snk_ready;
  assign dump_busy      = (state_q != StIdle);
  assign src_valid      = (state_q == StHold);
  assign src_data       = src_data_q;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = {4{avm_chipselect_q}};

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    overflow_d       = overflow_q;
    wait_d           = '0;
    src_data_d       = src_data_q;
    avm_chipselect_d = 1'b0;
    avm_write_d      = 1'b0;
    avm_address_d    = avm_address_q;
    avm_writedata_d  = avm_writedata_q;

    if (clear) begin
      // An access already on the bus still completes; only the bookkeeping is dropped.
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            avm_chipselect_d = 1'b1;
            avm_write_d      = 1'b1;
            avm_address_d    = wr_ptr_q;
            avm_writedata_d  = snk_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if (count_q == DepthCnt) begin
              // Full: the oldest entry is overwritten, so the read side moves on too.
              rd_ptr_d   = rd_ptr_q + 1'b1;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
          if (dump_start && ((count_q != '0) || accept)) begin
            state_d = StRdIssue;
          end
        end
        StRdIssue: begin
          avm_chipselect_d = 1'b1;
          avm_address_d    = rd_ptr_q;
          state_d          = StRdWait;
        end
        StRdWait: begin
          // wait_q is 0 while the read is on the bus; data is valid READ_LATENCY later.
          wait_d = wait_q + 2'd1;
          if (wait_q == 2'(READ_LATENCY)) begin
            src_data_d = avm_readdata;
            wait_d     = '0;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (src_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            state_d  = (count_q == 1) ? StIdle : StRdIssue;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      overflow_q       <= 1'b0;
      wait_q           <= '0;
      src_data_q       <= '0;
      avm_chipselect_q <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      overflow_q       <= overflow_d;
      wait_q           <= wait_d;
      src_data_q       <= src_data_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
    end
  end

endmodule

// File: tb/tb_sram_ring_logger.sv
// Bench for sram_ring_logger: a 4-entry logger with read latency 1 is checked
// against a queue model of the log. A second logger with read latency 2 is used
// only to check dump timing.
module tb_sram_ring_logger;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        snk_valid, dump_start, clear, src_ready;
  logic [31:0] snk_data;
  logic        snk_ready, dump_busy, src_valid, overflow;
  logic [31:0] src_data, avm_writedata, avm_readdata;
  logic [2:0]  count;
  logic [1:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write;

  logic        snk_valid2, dump_start2, src_ready2;
  logic [31:0] snk_data2;
  logic        snk_ready2, dump_busy2, src_valid2, overflow2;
  logic [31:0] src_data2, avm_writedata2, avm_readdata2;
  logic [2:0]  count2;
  logic [1:0]  avm_address2;
  logic [3:0]  avm_byteenable2;
  logic        avm_chipselect2, avm_write2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_ring_logger #(.ADDR_W(2), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .snk_valid(snk_valid), .snk_data(snk_data),
    .snk_ready(snk_ready), .dump_start(dump_start), .clear(clear), .dump_busy(dump_busy),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready), .count(count),
    .overflow(overflow), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  sram_ring_logger #(.ADDR_W(2), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .snk_valid(snk_valid2), .snk_data(snk_data2),
    .snk_ready(snk_ready2), .dump_start(dump_start2), .clear(1'b0), .dump_busy(dump_busy2),
    .src_valid(src_valid2), .src_data(src_data2), .src_ready(src_ready2), .count(count2),
    .overflow(overflow2), .avm_address(avm_address2), .avm_byteenable(avm_byteenable2),
    .avm_chipselect(avm_chipselect2), .avm_write(avm_write2),
    .avm_writedata(avm_writedata2), .avm_readdata(avm_readdata2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM models; read data is random junk except in the cycle it is valid.
  logic [31:0] mem1 [Depth];
  logic [31:0] mem2 [Depth];
  logic [31:0] rd_pipe2;
  logic        rd_pipe2_v;
  always @(posedge clk) begin
    if (avm_chipselect && avm_write) mem1[avm_address] <= avm_writedata;
    avm_readdata <= (avm_chipselect && !avm_write) ? mem1[avm_address] : $urandom;
    if (avm_chipselect2 && avm_write2) mem2[avm_address2] <= avm_writedata2;
    rd_pipe2      <= mem2[avm_address2];
    rd_pipe2_v    <= avm_chipselect2 && !avm_write2;
    avm_readdata2 <= rd_pipe2_v ? rd_pipe2 : $urandom;
  end

  // Reference model of the log: oldest entry at the front.
  logic [31:0] q [$];
  int          wr_idx = 0;
  logic        m_ovf = 1'b0;
  logic        exp_wr = 1'b0;
  logic [1:0]  exp_addr;
  logic [31:0] exp_data;

  always @(posedge clk) begin
    exp_wr = 1'b0;
    if (reset || clear) begin
      q.delete();
      wr_idx = 0;
      m_ovf  = 1'b0;
    end else begin
      if (snk_valid && snk_ready) begin
        exp_wr   = 1'b1;
        exp_addr = 2'(wr_idx % Depth);
        exp_data = snk_data;
        wr_idx++;
        q.push_back(snk_data);
        if (q.size() > Depth) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (src_valid && src_ready) begin
        if (q.size() == 0) chk("pop_empty_log", 32'd1, 32'd0);
        else chk("src_data", src_data, q.pop_front());
      end
    end
  end

  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      chk("count", 32'(count), q.size());
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("wr_strobe", 32'(avm_chipselect && avm_write), 32'(exp_wr));
      if (exp_wr) begin
        chk("wr_addr", 32'(avm_address), 32'(exp_addr));
        chk("wr_data", avm_writedata, exp_data);
      end
      chk("byteenable", 32'(avm_byteenable), avm_chipselect ? 32'hF : 32'h0);
      if (avm_chipselect && !avm_write) begin
        chk("rd_only_in_dump", 32'(dump_busy), 32'd1);
        chk("rd_addr", 32'(avm_address), 32'((wr_idx - q.size()) % Depth));
      end
      if (dump_busy) chk("snk_ready_busy", 32'(snk_ready), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(src_valid), 32'd1);
        chk("hold_data", src_data, prev_data);
      end
      prev_hold = src_valid && !src_ready && !clear;
      prev_data = src_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!dump_busy) break;
      step();
    end
    chk(tag, 32'(dump_busy), 32'd0);
  endtask

  task automatic push(input logic [31:0] d);
    snk_valid = 1'b1;
    snk_data  = d;
    step();
    snk_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; snk_valid = 1'b0; snk_data = '0; dump_start = 1'b0; clear = 1'b0;
    src_ready = 1'b0; snk_valid2 = 1'b0; snk_data2 = '0; dump_start2 = 1'b0;
    src_ready2 = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_snk_ready", 32'(snk_ready), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_src_valid", 32'(src_valid), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_snk_ready", 32'(snk_ready), 32'd1);

    // Three back-to-back samples land at addresses 0..2.
    for (int i = 0; i < 3; i++) begin
      snk_valid = 1'b1;
      snk_data  = 32'hA0 + 32'(i);
      step();
      chk("t1_wr_addr", 32'(avm_address), 32'(i));
    end
    snk_valid = 1'b0;
    step();
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // Dump with the consumer always ready: read at N+2, first word at N+4.
    src_ready  = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("t2_busy", 32'(dump_busy), 32'd1);
    step();
    chk("t2_rd_issue", 32'(avm_chipselect && !avm_write), 32'd1);
    chk("t2_rd_addr0", 32'(avm_address), 32'd0);
    step();
    chk("t2_valid_n3", 32'(src_valid), 32'd0);
    step();
    chk("t2_valid_n4", 32'(src_valid), 32'd1);
    chk("t2_first_word", src_data, 32'hA0);
    wait_idle("t2_dump_done");
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_drained", q.size(), 32'd0);

    // Wrap: six samples into four entries keep 3..6, write pointer ends at 2.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("no_access_after_reset", 32'(avm_chipselect), 32'd0);
    for (int i = 1; i <= 6; i++) push(32'(i));
    step();
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_oldest", q[0], 32'd3);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_idle("t3_dump_done");
    push(32'h77);
    chk("t3_wr_wrap_addr", 32'(avm_address), 32'd2);

    // Consumer stalls for five cycles on the first dumped word.
    for (int i = 0; i < 3; i++) push(32'h10 + 32'(i));
    src_ready  = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 10 && !src_valid; i++) step();
    chk("t4_valid", 32'(src_valid), 32'd1);
    chk("t4_word", src_data, 32'h77);
    snk_valid = 1'b1;
    snk_data  = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stable", src_data, 32'h77);
      chk("t4_no_access", 32'(avm_chipselect), 32'd0);
      chk("t4_snk_ready", 32'(snk_ready), 32'd0);
    end
    snk_valid = 1'b0;
    src_ready = 1'b1;
    wait_idle("t4_dump_done");
    chk("t4_drained", q.size(), 32'd0);

    // Clear while a read is outstanding.
    for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    chk("t5_rd_on_bus", 32'(avm_chipselect && !avm_write), 32'd1);
    clear = 1'b1;
    chk("t5_snk_ready_clear", 32'(snk_ready), 32'd0);
    step();
    clear = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_src_valid", 32'(src_valid), 32'd0);
    chk("t5_busy", 32'(dump_busy), 32'd0);
    push(32'h55);
    chk("t5_wr", 32'(avm_chipselect && avm_write), 32'd1);
    chk("t5_wr_addr", 32'(avm_address), 32'd0);
    chk("t5_wr_data", avm_writedata, 32'h55);

    // Dump request on an empty log is ignored.
    clear = 1'b1;
    step();
    clear = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_busy", 32'(dump_busy), 32'd0);
      chk("t6_no_access", 32'(avm_chipselect), 32'd0);
      step();
    end

    // Read latency 2: first word at N+5.
    snk_valid2 = 1'b1;
    snk_data2  = 32'h99;
    step();
    snk_valid2  = 1'b0;
    dump_start2 = 1'b1;
    step();
    dump_start2 = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("t7_valid_early", 32'(src_valid2), 32'd0);
    end
    step();
    chk("t7_valid_n5", 32'(src_valid2), 32'd1);
    chk("t7_word", src_data2, 32'h99);
    src_ready2 = 1'b1;
    step();
    chk("t7_busy", 32'(dump_busy2), 32'd0);
    chk("t7_count", 32'(count2), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      snk_valid  = ($urandom_range(0, 2) != 0);
      snk_data   = $urandom;
      dump_start = ($urandom_range(0, 15) == 0);
      clear      = ($urandom_range(0, 63) == 0);
      src_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    snk_valid = 1'b0; dump_start = 1'b0; clear = 1'b0; src_ready = 1'b1;
    wait_idle("rand_dump_done");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
